// File: rtl/data_stream_pkt_chk_if.sv
// Data-stream flit interface between a NAP and user logic; tx drives flits, rx returns ready.
interface t_DATA_STREAM #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4
);
    logic                  ready;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sop;
    logic                  eop;

    modport tx (input ready, output valid, data, addr, sop, eop);
    modport rx (output ready, input valid, data, addr, sop, eop);
endinterface

// File: rtl/data_stream_pkt_chk.sv
// Receive-side flit checker: regenerates the transmitter's sequence locally, compares every
// accepted beat and reports beat count, saturating error count and a sticky fail flag.

module random_seq_gen #(
    parameter int OUTPUT_WIDTH = 256,
    parameter int WORD_WIDTH   = 8,
    parameter int LINEAR_COUNT = 0,
    parameter int COUNT_DOWN   = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_enable,
    output logic [OUTPUT_WIDTH-1:0] o_dout
);
    localparam int unsigned NUM_WORDS = OUTPUT_WIDTH / WORD_WIDTH;
    localparam logic [WORD_WIDTH-1:0] LFSR_TAPS = WORD_WIDTH'(8'hB8);

    logic [OUTPUT_WIDTH-1:0] dout_q, dout_d, seed;
    logic [WORD_WIDTH-1:0]   word;

    always_comb begin
        seed   = '0;
        dout_d = dout_q;
        word   = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++)
            seed[i*WORD_WIDTH +: WORD_WIDTH] = (LINEAR_COUNT != 0) ? WORD_WIDTH'(i)
                                                                   : WORD_WIDTH'(i % 255 + 1);
        // Sequence is parked at its seed while start is low, so every start begins identically.
        if (!i_start) begin
            dout_d = seed;
        end else if (i_enable) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                word = dout_q[i*WORD_WIDTH +: WORD_WIDTH];
                if (LINEAR_COUNT != 0)
                    word = (COUNT_DOWN != 0) ? word - WORD_WIDTH'(1) : word + WORD_WIDTH'(1);
                else
                    word = {word[WORD_WIDTH-2:0], ^(word & LFSR_TAPS)};
                dout_d[i*WORD_WIDTH +: WORD_WIDTH] = word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) dout_q <= seed;
        else            dout_q <= dout_d;
    end

    assign o_dout = dout_q;
endmodule

module data_stream_pkt_chk #(
    parameter int LINEAR_PKTS    = 0,
    parameter int TGT_DATA_WIDTH = 0,
    parameter int CHECK_ADDR     = 1,
    parameter int BACKPRESSURE   = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_enable,
    input  logic [3:0]           i_exp_addr,
    t_DATA_STREAM.rx             if_data_stream,
    output logic [CNT_WIDTH-1:0] o_beat_count,
    output logic [CNT_WIDTH-1:0] o_error_count,
    output logic                 o_fail,
    output logic                 o_running
);
    // Zero width is not a usable configuration; fall back to a single byte so elaboration succeeds.
    localparam int DW = (TGT_DATA_WIDTH > 0) ? TGT_DATA_WIDTH : 8;

    typedef enum logic [1:0] {CHK_IDLE, CHK_FIRST, CHK_RUNNING} chk_state_t;

    chk_state_t           state_q, state_d;
    logic                 config_enable_q, config_enable_d;
    logic                 start_prev_q, start_prev_d;
    logic                 start_edge_detect_q, start_edge_detect_d;
    logic                 ready_q, ready_d;
    logic                 running_q, running_d;
    logic [1:0]           bp_cnt_q, bp_cnt_d;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0] error_count_q, error_count_d;
    logic                 fail_q, fail_d;

    logic          start_edge, first_pulse, accept, mismatch, throttle_ok, gen_enable;
    logic [DW-1:0] exp_data;
    logic          unused_sop_eop;

    always_comb begin
        start_edge  = i_start & ~start_prev_q;
        first_pulse = (state_q == CHK_FIRST) & start_edge_detect_q;
        accept      = if_data_stream.valid & ready_q;
        mismatch    = (if_data_stream.data != exp_data) |
                      ((CHECK_ADDR != 0) & (if_data_stream.addr != i_exp_addr));
        gen_enable  = first_pulse | accept;

        config_enable_d     = i_enable;
        start_prev_d        = i_start;
        start_edge_detect_d = start_edge | (start_edge_detect_q & ~first_pulse);

        state_d = state_q;
        case (state_q)
            // The edge is seen combinationally here so a fresh start always passes through FIRST.
            CHK_IDLE:
                if (i_start & config_enable_q)
                    state_d = (start_edge_detect_q | start_edge) ? CHK_FIRST : CHK_RUNNING;
            CHK_FIRST:
                if (!i_start)                 state_d = CHK_IDLE;
                else if (start_edge_detect_q) state_d = CHK_RUNNING;
            CHK_RUNNING:
                if (!i_start) state_d = CHK_IDLE;
            default:
                state_d = CHK_IDLE;
        endcase

        bp_cnt_d    = (state_d == CHK_RUNNING) ? bp_cnt_q + 2'd1 : '0;
        throttle_ok = (BACKPRESSURE == 0) | (bp_cnt_q != 2'd3);
        ready_d     = (state_d == CHK_RUNNING) & config_enable_q & throttle_ok;
        running_d   = (state_d == CHK_RUNNING);

        beat_count_d  = beat_count_q;
        error_count_d = error_count_q;
        fail_d        = fail_q;
        if (start_edge) begin
            beat_count_d  = '0;
            error_count_d = '0;
            fail_d        = 1'b0;
        end else if (accept) begin
            beat_count_d = beat_count_q + CNT_WIDTH'(1);
            if (mismatch) begin
                if (error_count_q != '1) error_count_d = error_count_q + CNT_WIDTH'(1);
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q             <= CHK_IDLE;
            config_enable_q     <= 1'b0;
            start_prev_q        <= 1'b0;
            start_edge_detect_q <= 1'b0;
            ready_q             <= 1'b0;
            running_q           <= 1'b0;
            bp_cnt_q            <= '0;
            beat_count_q        <= '0;
            error_count_q       <= '0;
            fail_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            config_enable_q     <= config_enable_d;
            start_prev_q        <= start_prev_d;
            start_edge_detect_q <= start_edge_detect_d;
            ready_q             <= ready_d;
            running_q           <= running_d;
            bp_cnt_q            <= bp_cnt_d;
            beat_count_q        <= beat_count_d;
            error_count_q       <= error_count_d;
            fail_q              <= fail_d;
        end
    end

    random_seq_gen #(
        .OUTPUT_WIDTH (DW),
        .WORD_WIDTH   (8),
        .LINEAR_COUNT (LINEAR_PKTS),
        .COUNT_DOWN   (0)
    ) u_exp_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_start),
        .i_enable  (gen_enable),
        .o_dout    (exp_data)
    );

    assign unused_sop_eop       = if_data_stream.sop ^ if_data_stream.eop;
    assign if_data_stream.ready = ready_q;
    assign o_beat_count         = beat_count_q;
    assign o_error_count        = error_count_q;
    assign o_fail               = fail_q;
    assign o_running            = running_q;
endmodule
